// File: rtl/ps2_host_tx_if.sv
// Command-byte handshake between the keyboard-controller register and the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic       tx_valid_i;
  logic [7:0] tx_data_i;
  logic       tx_ready_o;
  logic       busy_o;
  logic       done_o;
  logic       error_o;

  modport master (
    output tx_valid_i,
    output tx_data_i,
    input  tx_ready_o,
    input  busy_o,
    input  done_o,
    input  error_o
  );

  modport slave (
    input  tx_valid_i,
    input  tx_data_i,
    output tx_ready_o,
    output busy_o,
    output done_o,
    output error_o
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, device-clocked shift, ack check.
// Drives open-drain pull-low enables only; tri-states are built at the top level.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000,
  parameter int unsigned FILTER_CYCLES  = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         ps2_clk_i,
  input  logic         ps2_data_i,
  output logic         ps2_clk_oe_o,
  output logic         ps2_data_oe_o,
  ps2_host_tx_if.slave tx_if
);

  localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned FLT_W = $clog2(FILTER_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_SHIFT,
    ST_ACK,
    ST_WAIT_IDLE
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic             parity_q, parity_d;
  logic [INH_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_q, bit_d;
  logic [TMO_W-1:0] tmr_q, tmr_d;
  logic             nack_q, nack_d;

  logic clk_oe_q, clk_oe_d;
  logic data_oe_q, data_oe_d;
  logic ready_q, ready_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic error_q, error_d;

  logic [1:0]       clk_sync_q, clk_sync_d;
  logic [1:0]       data_sync_q, data_sync_d;
  logic             filt_clk_q, filt_clk_d;
  logic [FLT_W-1:0] filt_cnt_q, filt_cnt_d;

  logic clk_s;
  logic data_s;
  logic fall;
  logic accept;
  logic inh_done;
  logic timeout;

  // Input conditioning: the filtered clock only moves after FILTER_CYCLES
  // consecutive samples disagree with it; fall marks the 1->0 flip.
  always_comb begin
    clk_sync_d  = {clk_sync_q[0], ps2_clk_i};
    data_sync_d = {data_sync_q[0], ps2_data_i};
    clk_s       = clk_sync_q[1];
    data_s      = data_sync_q[1];
    filt_clk_d  = filt_clk_q;
    filt_cnt_d  = '0;
    fall        = 1'b0;
    if (clk_s != filt_clk_q) begin
      if (filt_cnt_q == FLT_W'(FILTER_CYCLES - 1)) begin
        filt_clk_d = clk_s;
        fall       = filt_clk_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  assign accept   = tx_if.tx_valid_i && ready_q;
  assign inh_done = (cnt_q == INH_W'(INHIBIT_CYCLES - 1));
  assign timeout  = (tmr_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      byte_q      <= '0;
      parity_q    <= 1'b0;
      cnt_q       <= '0;
      bit_q       <= '0;
      tmr_q       <= '0;
      nack_q      <= 1'b0;
      clk_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      filt_clk_q  <= 1'b1;
      filt_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      byte_q      <= byte_d;
      parity_q    <= parity_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      tmr_q       <= tmr_d;
      nack_q      <= nack_d;
      clk_oe_q    <= clk_oe_d;
      data_oe_q   <= data_oe_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      filt_clk_q  <= filt_clk_d;
      filt_cnt_q  <= filt_cnt_d;
    end
  end

  // Next state; timeout is tested before any clock edge so it wins a tie.
  always_comb begin
    state_d  = state_q;
    byte_d   = byte_q;
    parity_d = parity_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    tmr_d    = tmr_q;
    nack_d   = nack_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          byte_d   = tx_if.tx_data_i;
          parity_d = ~^tx_if.tx_data_i;
          cnt_d    = '0;
          state_d  = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (inh_done) state_d = ST_RTS;
        else          cnt_d   = cnt_q + 1'b1;
      end
      ST_RTS: begin
        tmr_d   = '0;
        bit_d   = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        tmr_d = tmr_q + 1'b1;
        if (timeout) begin
          state_d = ST_IDLE;
        end else if (fall) begin
          bit_d = bit_q + 1'b1;
          if (bit_q == 4'd9) state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        tmr_d = tmr_q + 1'b1;
        if (timeout) begin
          state_d = ST_IDLE;
        end else if (fall) begin
          nack_d  = data_s;
          state_d = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        tmr_d = tmr_q + 1'b1;
        if (timeout || (filt_clk_q && data_s)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs, computed from the transition being taken this cycle.
  always_comb begin
    done_d    = 1'b0;
    error_d   = 1'b0;
    data_oe_d = data_oe_q;
    case (state_q)
      ST_IDLE:    data_oe_d = 1'b0;
      ST_INHIBIT: data_oe_d = inh_done;
      ST_RTS:     data_oe_d = 1'b1;
      ST_SHIFT: begin
        if (timeout) begin
          data_oe_d = 1'b0;
          done_d    = 1'b1;
          error_d   = 1'b1;
        end else if (fall) begin
          if (bit_q < 4'd8)       data_oe_d = ~byte_q[bit_q[2:0]];
          else if (bit_q == 4'd8) data_oe_d = ~parity_q;
          else                    data_oe_d = 1'b0;
        end
      end
      ST_ACK: begin
        data_oe_d = 1'b0;
        if (timeout) begin
          done_d  = 1'b1;
          error_d = 1'b1;
        end
      end
      ST_WAIT_IDLE: begin
        data_oe_d = 1'b0;
        if (timeout) begin
          done_d  = 1'b1;
          error_d = 1'b1;
        end else if (filt_clk_q && data_s) begin
          done_d  = 1'b1;
          error_d = nack_q;
        end
      end
      default: data_oe_d = 1'b0;
    endcase
    clk_oe_d = (state_d == ST_INHIBIT) || (state_d == ST_RTS);
    busy_d   = (state_d != ST_IDLE);
    ready_d  = (state_d == ST_IDLE);
  end

  assign ps2_clk_oe_o     = clk_oe_q;
  assign ps2_data_oe_o    = data_oe_q;
  assign tx_if.tx_ready_o = ready_q;
  assign tx_if.busy_o     = busy_q;
  assign tx_if.done_o     = done_q;
  assign tx_if.error_o    = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple PS/2 device model on the open-drain lines.
module tb_ps2_host_tx;

  localparam int unsigned INH = 5000;
  localparam int unsigned TMO = 3000;
  localparam int unsigned FLT = 8;
  localparam int unsigned H   = 20;

  localparam int M_ACK       = 0;
  localparam int M_NACK      = 1;
  localparam int M_GLITCH    = 2;
  localparam int M_BUSYVALID = 3;
  localparam int M_RESET     = 4;
  localparam int M_TIMEOUT   = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;
  logic clk_oe;
  logic data_oe;
  logic ps2_clk_line;
  logic ps2_data_line;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  assign ps2_clk_line  = clk_oe  ? 1'b0 : dev_clk;
  assign ps2_data_line = data_oe ? 1'b0 : dev_data;

  ps2_host_tx_if ifc ();

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .FILTER_CYCLES (FLT)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .ps2_clk_i    (ps2_clk_line),
    .ps2_data_i   (ps2_data_line),
    .ps2_clk_oe_o (clk_oe),
    .ps2_data_oe_o(data_oe),
    .tx_if        (ifc)
  );

  always @(negedge clk) if (ifc.done_o) done_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // exp_line[e-1] is the data line level the host must present after falling edge e.
  task automatic send(input logic [7:0] b, input logic [9:0] exp_line, input int mode);
    int   n;
    int   snap;
    logic exp_oe;
    n = 0;
    while (!ifc.tx_ready_o && n < 100) begin tick(); n++; end
    check_eq("ready_before", ifc.tx_ready_o, 1);
    ifc.tx_data_i  = b;
    ifc.tx_valid_i = 1'b1;
    tick();
    ifc.tx_valid_i = 1'b0;
    check_eq("ready_drop", ifc.tx_ready_o, 0);
    check_eq("busy_set", ifc.busy_o, 1);

    n = 0;
    while (clk_oe && !data_oe && n < INH + 100) begin n++; tick(); end
    check_eq("inhibit_len", n, INH);
    n = 0;
    while (clk_oe && data_oe && n < 10) begin n++; tick(); end
    check_eq("rts_len", n, 1);
    check_eq("start_bit", {clk_oe, data_oe}, 2'b01);

    if (mode == M_TIMEOUT) begin
      n = 0;
      while (!ifc.done_o && n < TMO + 100) begin tick(); n++; end
      check_eq("tmo_len", n, TMO);
      check_eq("tmo_err", ifc.error_o, 1);
      check_eq("tmo_oe", {clk_oe, data_oe}, 2'b00);
      tick();
      check_eq("tmo_ready", ifc.tx_ready_o, 1);
      return;
    end

    tick(30);
    for (int e = 1; e <= 10; e++) begin
      dev_clk = 1'b0;
      tick(H);
      exp_oe = ~exp_line[e-1];
      check_eq($sformatf("oe_edge%0d", e), data_oe, exp_oe);
      dev_clk = 1'b1;
      if (e == 4 && mode == M_GLITCH) begin
        tick(5);
        dev_clk = 1'b0;
        tick(3);
        dev_clk = 1'b1;
        tick(12);
        check_eq("glitch_hold", data_oe, exp_oe);
      end else if (e == 4 && mode == M_RESET) begin
        tick(5);
        snap  = done_cnt;
        rst_n = 1'b0;
        tick();
        check_eq("rst_oe", {clk_oe, data_oe}, 2'b00);
        check_eq("rst_ready", ifc.tx_ready_o, 1);
        check_eq("rst_busy", ifc.busy_o, 0);
        rst_n = 1'b1;
        tick(40);
        check_eq("rst_no_done", done_cnt, snap);
        return;
      end else if (e == 2 && mode == M_BUSYVALID) begin
        tick(5);
        ifc.tx_data_i  = ~b;
        ifc.tx_valid_i = 1'b1;
        tick();
        ifc.tx_valid_i = 1'b0;
        tick(14);
      end else begin
        tick(H);
      end
    end

    dev_clk  = 1'b0;
    dev_data = (mode == M_NACK);
    tick(H);
    dev_clk = 1'b1;
    n = 0;
    while (!ifc.done_o && n < 200) begin
      tick();
      n++;
      if (n == 5) dev_data = 1'b1;
    end
    dev_data = 1'b1;
    check_eq("done_seen", ifc.done_o, 1);
    check_eq("error", ifc.error_o, (mode == M_NACK));
    check_eq("released", {clk_oe, data_oe}, 2'b00);
    tick();
    check_eq("ready_after", ifc.tx_ready_o, 1);
    check_eq("busy_after", ifc.busy_o, 0);
    check_eq("done_pulse", ifc.done_o, 0);
    if (mode == M_BUSYVALID) begin
      tick(5);
      check_eq("ignored_byte", ifc.busy_o, 0);
    end
  endtask

  initial begin
    ifc.tx_valid_i = 1'b0;
    ifc.tx_data_i  = '0;
    rst_n = 1'b0;
    tick(3);
    check_eq("rst_clk_oe", clk_oe, 0);
    check_eq("rst_data_oe", data_oe, 0);
    check_eq("rst_ready", ifc.tx_ready_o, 1);
    check_eq("rst_busy", ifc.busy_o, 0);
    check_eq("rst_done", ifc.done_o, 0);
    check_eq("rst_error", ifc.error_o, 0);
    rst_n = 1'b1;
    tick(20);

    send(8'hED, 10'b11_11101101, M_ACK);
    send(8'h01, 10'b10_00000001, M_GLITCH);
    send(8'hFF, 10'b11_11111111, M_BUSYVALID);
    send(8'h55, 10'b11_01010101, M_NACK);
    send(8'hA5, 10'b11_10100101, M_RESET);
    send(8'h3C, 10'b11_00111100, M_TIMEOUT);
    tick(20);
    send(8'hED, 10'b11_11101101, M_ACK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
